// File: rtl/sms23_pkg.sv
// sms23_pkg: shared types and helpers for the SMS23 inverse S-box.
//   gf64_t  : 6-bit tower element, bit pairs [1:0],[3:2],[5:4] = c0,c1,c2
//   gf4_t   : 2-bit GF(4) element in normal basis {w, w^2}
//   state_e : sequencer states
//   gf4_mul / gf4_sq / gf4_mulw : GF(4) primitives
//   l2_inv / l1_inv             : input and output linear layers
package sms23_pkg;

    typedef logic [5:0] gf64_t;
    typedef logic [1:0] gf4_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_DONE
    } state_e;

    // Normal-basis product: w*w = w^2, w^2*w^2 = w, w*w^2 = 1 = w + w^2.
    function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
        logic t;
        t = (a[0] & b[1]) ^ (a[1] & b[0]);
        return {(a[0] & b[0]) ^ t, (a[1] & b[1]) ^ t};
    endfunction

    function automatic gf4_t gf4_sq(input gf4_t a);
        return {a[0], a[1]};
    endfunction

    // Multiply by the extension constant w (reduction x^3 = w).
    function automatic gf4_t gf4_mulw(input gf4_t a);
        return {a[0] ^ a[1], a[1]};
    endfunction

    function automatic gf64_t l2_inv(input gf64_t b);
        gf64_t t;
        t[0] = b[0] ^ b[1] ^ b[2] ^ b[3];
        t[1] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        t[2] = b[0] ^ b[1] ^ b[2] ^ b[4];
        t[3] = b[0] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        t[4] = b[0] ^ b[4] ^ b[5];
        t[5] = b[0] ^ b[1] ^ b[4];
        return t;
    endfunction

    function automatic gf64_t l1_inv(input gf64_t p);
        gf64_t y;
        y[0] = p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[5];
        y[1] = p[0] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
        y[2] = p[1] ^ p[4] ^ p[5];
        y[3] = p[0] ^ p[2] ^ p[4];
        y[4] = p[0] ^ p[1] ^ p[4] ^ p[5];
        y[5] = p[1] ^ p[2] ^ p[3] ^ p[4];
        return y;
    endfunction

endpackage

// File: rtl/gf43_mul.sv
// gf43_mul: combinational GF((2^2)^3) multiplier, polynomial basis over
// GF(4) modulo x^3 + w (irreducible: no GF(4) element cubes to w).
//   a_i, b_i : operands
//   c_o      : product
module gf43_mul
    import sms23_pkg::*;
(
    input  gf64_t a_i,
    input  gf64_t b_i,
    output gf64_t c_o
);

    gf4_t a0, a1, a2, b0, b1, b2;
    gf4_t d0, d1, d2, d3, d4;

    assign {a2, a1, a0} = a_i;
    assign {b2, b1, b0} = b_i;

    // Schoolbook partial products, degree 0..4.
    assign d0 = gf4_mul(a0, b0);
    assign d1 = gf4_mul(a0, b1) ^ gf4_mul(a1, b0);
    assign d2 = gf4_mul(a0, b2) ^ gf4_mul(a1, b1) ^ gf4_mul(a2, b0);
    assign d3 = gf4_mul(a1, b2) ^ gf4_mul(a2, b1);
    assign d4 = gf4_mul(a2, b2);

    // x^3 = w, x^4 = w*x: fold the high terms back down.
    assign c_o = {d2, d1 ^ gf4_mulw(d4), d0 ^ gf4_mulw(d3)};

endmodule

// File: rtl/sms23_5_inv_seq.sv
// sms23_5_inv_seq: iterative inverse S-box, y -> L1^-1((L2^-1(y))^5).
// One shared tower multiplier: p^2, p^4, then p^4 * p.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data = S-box output y
//   out_valid/out_ready  : output handshake, out_data registered
//   busy                 : high while multiplying (MUL1..MUL3)
module sms23_5_inv_seq
    import sms23_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic       busy
);

    state_e state_q;
    gf64_t  base_q;
    gf64_t  acc_q;
    gf64_t  out_data_q;
    logic   out_valid_q;
    gf64_t  mul_b;
    gf64_t  acc_d;

    // Squaring steps use acc*acc; the final step folds in the original p.
    assign mul_b = (state_q == S_MUL3) ? base_q : acc_q;

    gf43_mul u_mul (
        .a_i (acc_q),
        .b_i (mul_b),
        .c_o (acc_d)
    );

    assign in_ready  = rst_n && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && out_ready));
    assign busy      = rst_n && ((state_q == S_MUL1) || (state_q == S_MUL2) ||
                                 (state_q == S_MUL3));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            base_q      <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        base_q  <= l2_inv(in_data);
                        acc_q   <= l2_inv(in_data);
                        state_q <= S_MUL1;
                    end
                end
                S_MUL1: begin
                    acc_q   <= acc_d;
                    state_q <= S_MUL2;
                end
                S_MUL2: begin
                    acc_q   <= acc_d;
                    state_q <= S_MUL3;
                end
                S_MUL3: begin
                    out_data_q  <= l1_inv(acc_d);
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    // Result held until taken; a waiting operand is loaded
                    // in the same cycle so the pipeline turns in 4 cycles.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            base_q  <= l2_inv(in_data);
                            acc_q   <= l2_inv(in_data);
                            state_q <= S_MUL1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
